control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL: Clock  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL: Clear  input  1  reset; asynchronous, active-low.
REQ-003 SHALL: IR  input  32  instruction register contents; opcode = IR[31:27]; valid from T3 onward.
REQ-004 SHALL: CON  input  1  branch condition flip-flop output from datapath.
REQ-005 SHALL: Mem_Ready  input  1  memory handshake; high when requested read/write completes this cycle.
REQ-006 SHALL: PCout, Zlowout, MDRout, Cout, BAout, Rout  output  1 each  bus-driver selects.
REQ-007 SHALL: PCin, IRin, MARin, MDRin, Yin, Zin, Rin, CONin  output  1 each  register loads.
REQ-008 SHALL: Gra, Grb, Grc  output  1 each  register-field selects.
REQ-009 SHALL: IncPC, ADD, AND, OR, Read, Write  output  1 each  ALU ops and memory strobes.
REQ-010 SHALL: Run  output  1  high while executing; low in Reset and Halt states.
REQ-011 SHALL: Illegal  output  1  one-cycle pulse in T3 on an unsupported opcode.

Function
REQ-012 SHALL: The FSM has states Reset, T0..T7 and Halt, with 4-bit encoding in one registered state variable.
REQ-013 SHALL: Outputs are combinational decodes of the present state and IR[31:27]; an output not listed for a state is 0.
REQ-014 SHALL: Opcodes are ld=0, ldi=1, st=2, addi=3, andi=4, ori=5, br=6, halt=7; opcodes 8-31 are unsupported.
REQ-015 SHALL: Fetch is T0: PCout, MARin, IncPC, Zin; T1: Zlowout, PCin, Read, MDRin; T2: MDRout, IRin.
REQ-016 SHALL: In T1, the FSM holds T1 with Read asserted until Mem_Ready=1, then advances to T2; PCin pulses only in the cycle Mem_Ready=1.
REQ-017 SHALL: ld is T3: Grb, BAout, Yin; T4: Cout, ADD, Zin; T5: Zlowout, MARin; T6: Read, MDRin, held until Mem_Ready; T7: MDRout, Gra, Rin.
REQ-018 SHALL: ldi is T3..T4 as for ld; T5: Zlowout, Gra, Rin; then T0.
REQ-019 SHALL: st is T3..T5 as for ld; T6: Gra, Rout, MDRin; T7: Write, held until Mem_Ready; then T0.
REQ-020 SHALL: addi/andi/ori are T3: Grb, Rout, Yin; T4: Cout, ADD/AND/OR respectively, Zin; T5: Zlowout, Gra, Rin; then T0.
REQ-021 SHALL: br is T3: Gra, Rout, CONin; T4: PCout, Yin; T5: Cout, ADD, Zin; T6: Zlowout, and PCin only if CON=1; then T0.
REQ-022 SHALL: halt enters Halt from T3 and remains there until reset; Run=0.
REQ-023 SHALL: An unsupported opcode pulses Illegal in T3 and returns to T0 with no register loads.
REQ-024 SHALL: The last state of each instruction transitions directly to T0 with no idle cycle.
REQ-025 SHALL: Reset asserted mid-instruction aborts it immediately, including any pending Mem_Ready wait.

Reset
REQ-026 SHALL: While Clear=0, the state is Reset and every output is 0.
REQ-027 SHALL: On the first rising edge after Clear rises, the state goes Reset->T0, with Run=1 from T0.

Configuration
REQ-028 SHALL: With macro CU_BRANCH_EN defined, opcode 6 executes per REQ-021.
REQ-029 SHALL: With CU_BRANCH_EN undefined, opcode 6 is unsupported per REQ-023 and CONin is tied to 0.

Verification
REQ-030 SHALL: Clear=0 for 3 cycles, then 1 -> all outputs 0 during reset; T0 with PCout=MARin=IncPC=Zin=1 on the first edge after Clear rises.
REQ-031 SHALL: ld (IR=0x00800005), Mem_Ready low for 2 cycles in T6 -> T6 lasts 3 cycles, then T7 with MDRout=Gra=Rin=1, then T0.
REQ-032 SHALL: br with CU_BRANCH_EN, CON=1 then CON=0 -> PCin=1 in T6 for the first; PCin=0 for the second; both return to T0.
REQ-033 SHALL: opcode 9 -> Illegal pulses 1 cycle in T3, next state T0, no Rin/PCin/MARin asserted.
REQ-034 SHALL: halt (IR=0x38000000) -> Halt reached after T3, Run=0 for 20 cycles; Clear pulse low -> restart at T0.
REQ-035 SHALL: Clear dropped during st T7 while waiting for Mem_Ready -> Write deasserts asynchronously and the state becomes Reset.

Source files
------------

// File: rtl/control_unit_if.sv
// Control-unit bundle: instruction/condition/memory-ready inputs and all control strobes.
// The control unit drives this bundle through the master modport, the datapath through slave.
interface control_unit_if;
  logic [31:0] IR;
  logic        CON;
  logic        Mem_Ready;

  logic PCout, Zlowout, MDRout, Cout, BAout, Rout;
  logic PCin, IRin, MARin, MDRin, Yin, Zin, Rin, CONin;
  logic Gra, Grb, Grc;
  logic IncPC, ADD, AND, OR, Read, Write;
  logic Run, Illegal;

  modport master (
    input  IR, CON, Mem_Ready,
    output PCout, Zlowout, MDRout, Cout, BAout, Rout,
    output PCin, IRin, MARin, MDRin, Yin, Zin, Rin, CONin,
    output Gra, Grb, Grc, IncPC, ADD, AND, OR, Read, Write, Run, Illegal
  );

  modport slave (
    output IR, CON, Mem_Ready,
    input  PCout, Zlowout, MDRout, Cout, BAout, Rout,
    input  PCin, IRin, MARin, MDRin, Yin, Zin, Rin, CONin,
    input  Gra, Grb, Grc, IncPC, ADD, AND, OR, Read, Write, Run, Illegal
  );
endinterface

// File: rtl/control_unit.sv
// Microsequencer for a bus CPU; opcode 6 (br) runs only when CU_BRANCH_EN is defined.
// Strobes decode combinationally from state+opcode; T1/T6(ld)/T7(st) stall until Mem_Ready.
module control_unit (
  input  logic           Clock,
  input  logic           Clear,
  control_unit_if.master cu
);

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9
  } state_t;

  state_t state, state_nxt;

  logic [4:0] opcode;
  logic       is_ld, is_ldi, is_st, is_addi, is_andi, is_ori, is_br, is_halt, is_alu;
  logic       unused_ir;

  assign opcode    = cu.IR[31:27];
  assign unused_ir = ^cu.IR[26:0];

  assign is_ld   = (opcode == 5'd0);
  assign is_ldi  = (opcode == 5'd1);
  assign is_st   = (opcode == 5'd2);
  assign is_addi = (opcode == 5'd3);
  assign is_andi = (opcode == 5'd4);
  assign is_ori  = (opcode == 5'd5);
  assign is_halt = (opcode == 5'd7);
  assign is_alu  = is_addi | is_andi | is_ori;

`ifdef CU_BRANCH_EN
  assign is_br = (opcode == 5'd6);
`else
  // Branch disabled: opcode 6 falls into the illegal path, so CONin can never assert.
  assign is_br = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) state <= S_RESET;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    {cu.PCout, cu.Zlowout, cu.MDRout, cu.Cout, cu.BAout, cu.Rout} = '0;
    {cu.PCin, cu.IRin, cu.MARin, cu.MDRin, cu.Yin, cu.Zin, cu.Rin, cu.CONin} = '0;
    {cu.Gra, cu.Grb, cu.Grc} = '0;
    {cu.IncPC, cu.ADD, cu.AND, cu.OR, cu.Read, cu.Write} = '0;
    cu.Illegal = 1'b0;
    cu.Run     = (state != S_RESET) && (state != S_HALT);

    case (state)
      S_RESET: state_nxt = S_T0;
      S_T0: begin
        {cu.PCout, cu.MARin, cu.IncPC, cu.Zin} = '1;
        state_nxt = S_T1;
      end
      S_T1: begin
        {cu.Zlowout, cu.Read, cu.MDRin} = '1;
        if (cu.Mem_Ready) begin
          cu.PCin   = 1'b1;
          state_nxt = S_T2;
        end
      end
      S_T2: begin
        {cu.MDRout, cu.IRin} = '1;
        state_nxt = S_T3;
      end
      S_T3: begin
        state_nxt = S_T4;
        if (is_ld || is_ldi || is_st) begin
          {cu.Grb, cu.BAout, cu.Yin} = '1;
        end else if (is_alu) begin
          {cu.Grb, cu.Rout, cu.Yin} = '1;
        end else if (is_br) begin
          {cu.Gra, cu.Rout, cu.CONin} = '1;
        end else if (is_halt) begin
          state_nxt = S_HALT;
        end else begin
          cu.Illegal = 1'b1;
          state_nxt  = S_T0;
        end
      end
      S_T4: begin
        state_nxt = S_T5;
        if (is_br) begin
          {cu.PCout, cu.Yin} = '1;
        end else begin
          {cu.Cout, cu.Zin} = '1;
          cu.ADD = !(is_andi || is_ori);
          cu.AND = is_andi;
          cu.OR  = is_ori;
        end
      end
      S_T5: begin
        if (is_ld || is_st) begin
          {cu.Zlowout, cu.MARin} = '1;
          state_nxt = S_T6;
        end else if (is_br) begin
          {cu.Cout, cu.ADD, cu.Zin} = '1;
          state_nxt = S_T6;
        end else begin
          {cu.Zlowout, cu.Gra, cu.Rin} = '1;
          state_nxt = S_T0;
        end
      end
      S_T6: begin
        if (is_ld) begin
          {cu.Read, cu.MDRin} = '1;
          if (cu.Mem_Ready) state_nxt = S_T7;
        end else if (is_st) begin
          {cu.Gra, cu.Rout, cu.MDRin} = '1;
          state_nxt = S_T7;
        end else begin
          cu.Zlowout = 1'b1;
          cu.PCin    = cu.CON;
          state_nxt  = S_T0;
        end
      end
      S_T7: begin
        if (is_ld) begin
          {cu.MDRout, cu.Gra, cu.Rin} = '1;
          state_nxt = S_T0;
        end else begin
          cu.Write = 1'b1;
          if (cu.Mem_Ready) state_nxt = S_T0;
        end
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized scoreboard bench for control_unit: per-cycle expected strobe words from a step-list model.
module tb_control_unit;

  logic Clock;
  logic Clear;

  control_unit_if cu ();

  control_unit dut (
    .Clock (Clock),
    .Clear (Clear),
    .cu    (cu)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

`ifdef CU_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  localparam logic [24:0] M_PCOUT   = 25'd1 << 0;
  localparam logic [24:0] M_ZLOWOUT = 25'd1 << 1;
  localparam logic [24:0] M_MDROUT  = 25'd1 << 2;
  localparam logic [24:0] M_COUT    = 25'd1 << 3;
  localparam logic [24:0] M_BAOUT   = 25'd1 << 4;
  localparam logic [24:0] M_ROUT    = 25'd1 << 5;
  localparam logic [24:0] M_PCIN    = 25'd1 << 6;
  localparam logic [24:0] M_IRIN    = 25'd1 << 7;
  localparam logic [24:0] M_MARIN   = 25'd1 << 8;
  localparam logic [24:0] M_MDRIN   = 25'd1 << 9;
  localparam logic [24:0] M_YIN     = 25'd1 << 10;
  localparam logic [24:0] M_ZIN     = 25'd1 << 11;
  localparam logic [24:0] M_RIN     = 25'd1 << 12;
  localparam logic [24:0] M_CONIN   = 25'd1 << 13;
  localparam logic [24:0] M_GRA     = 25'd1 << 14;
  localparam logic [24:0] M_GRB     = 25'd1 << 15;
  localparam logic [24:0] M_INCPC   = 25'd1 << 17;
  localparam logic [24:0] M_ADD     = 25'd1 << 18;
  localparam logic [24:0] M_AND     = 25'd1 << 19;
  localparam logic [24:0] M_OR      = 25'd1 << 20;
  localparam logic [24:0] M_READ    = 25'd1 << 21;
  localparam logic [24:0] M_WRITE   = 25'd1 << 22;
  localparam logic [24:0] M_RUN     = 25'd1 << 23;
  localparam logic [24:0] M_ILLEGAL = 25'd1 << 24;

  logic [24:0] act;
  assign act = {cu.Illegal, cu.Run, cu.Write, cu.Read, cu.OR, cu.AND, cu.ADD, cu.IncPC,
                cu.Grc, cu.Grb, cu.Gra, cu.CONin, cu.Rin, cu.Zin, cu.Yin, cu.MDRin,
                cu.MARin, cu.IRin, cu.PCin, cu.Rout, cu.BAout, cu.Cout, cu.MDRout,
                cu.Zlowout, cu.PCout};

  typedef struct {
    logic [24:0] w;    // strobes for this step
    bit          mw;   // step stalls until Mem_Ready
    logic [24:0] rdy;  // extra strobes in the Mem_Ready cycle
    bit          cp;   // PCin follows CON
  } step_t;

  step_t       prog[$];
  logic [24:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc_no = 0;

  // Monitor: every sampled cycle with a pending expectation is compared.
  always @(negedge Clock) begin
    logic [24:0] e;
    cyc_no++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (act !== e) begin
        n_err++;
        $display("FAIL ctrl_word cyc=%0d got=%07h exp=%07h diff=%07h", cyc_no, act, e, act ^ e);
      end
    end
  end

  function automatic void add(input logic [24:0] w, input bit mw = 1'b0,
                              input logic [24:0] rdy = '0, input bit cp = 1'b0);
    step_t s;
    s.w = w | M_RUN; s.mw = mw; s.rdy = rdy; s.cp = cp;
    prog.push_back(s);
  endfunction

  task automatic cyc(input bit clr, input bit mr, input bit con,
                     input logic [31:0] ir, input logic [24:0] w);
    @(posedge Clock);
    #1;
    Clear        = clr;
    cu.Mem_Ready = mr;
    cu.CON       = con;
    cu.IR        = ir;
    exp_q.push_back(w);
  endtask

  function automatic bit rbit();
    return bit'($urandom_range(0, 1));
  endfunction

  // mem_wait/con_force < 0 means random; abort drops Clear during the final memory stall.
  task automatic run_instr(input logic [31:0] ir, input int mem_wait,
                           input int con_force, input bit abort);
    logic [4:0] op;
    op = ir[31:27];
    prog.delete();
    add(M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
    add(M_ZLOWOUT | M_READ | M_MDRIN, 1'b1, M_PCIN);
    add(M_MDROUT | M_IRIN);
    case (op)
      5'd0: begin
        add(M_GRB | M_BAOUT | M_YIN); add(M_COUT | M_ADD | M_ZIN); add(M_ZLOWOUT | M_MARIN);
        add(M_READ | M_MDRIN, 1'b1); add(M_MDROUT | M_GRA | M_RIN);
      end
      5'd1: begin
        add(M_GRB | M_BAOUT | M_YIN); add(M_COUT | M_ADD | M_ZIN); add(M_ZLOWOUT | M_GRA | M_RIN);
      end
      5'd2: begin
        add(M_GRB | M_BAOUT | M_YIN); add(M_COUT | M_ADD | M_ZIN); add(M_ZLOWOUT | M_MARIN);
        add(M_GRA | M_ROUT | M_MDRIN); add(M_WRITE, 1'b1);
      end
      5'd3, 5'd4, 5'd5: begin
        add(M_GRB | M_ROUT | M_YIN);
        add(M_COUT | M_ZIN | (op == 5'd3 ? M_ADD : op == 5'd4 ? M_AND : M_OR));
        add(M_ZLOWOUT | M_GRA | M_RIN);
      end
      5'd6: begin
        if (BR_EN) begin
          add(M_GRA | M_ROUT | M_CONIN); add(M_PCOUT | M_YIN); add(M_COUT | M_ADD | M_ZIN);
          add(M_ZLOWOUT, 1'b0, '0, 1'b1);
        end else begin
          add(M_ILLEGAL);
        end
      end
      5'd7:    add('0);
      default: add(M_ILLEGAL);
    endcase
    foreach (prog[i]) begin
      logic [31:0] ir_d;
      int          k;
      bit          con;
      ir_d = $urandom();
      if (i >= 3) ir_d = ir;
      if (prog[i].mw) begin
        k = (i >= 3 && mem_wait >= 0) ? mem_wait : int'($urandom_range(0, 3));
        if (abort && i == prog.size() - 1) begin
          cyc(1'b1, 1'b0, rbit(), ir_d, prog[i].w);
          cyc(1'b0, 1'b0, rbit(), ir_d, '0);
          cyc(1'b0, 1'b1, rbit(), ir_d, '0);
          cyc(1'b1, 1'b0, rbit(), ir_d, '0);
          return;
        end
        repeat (k) cyc(1'b1, 1'b0, rbit(), ir_d, prog[i].w);
        cyc(1'b1, 1'b1, rbit(), ir_d, prog[i].w | prog[i].rdy);
      end else begin
        con = (con_force >= 0) ? con_force[0] : rbit();
        cyc(1'b1, rbit(), con, ir_d, prog[i].w | ((prog[i].cp && con) ? M_PCIN : '0));
      end
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op);
    logic [31:0] r;
    r = $urandom();
    return {op, r[26:0]};
  endfunction

  initial begin
    Clear        = 1'b1;
    cu.IR        = '0;
    cu.CON       = 1'b0;
    cu.Mem_Ready = 1'b0;
    #1 Clear = 1'b0;

    repeat (3) cyc(1'b0, 1'b0, 1'b0, 32'h0, '0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, '0);

    run_instr(32'h0080_0005, 2, -1, 1'b0);
    run_instr(mk_ir(5'd1), -1, -1, 1'b0);
    run_instr(mk_ir(5'd2), -1, -1, 1'b0);
    run_instr(mk_ir(5'd3), -1, -1, 1'b0);
    run_instr(mk_ir(5'd4), -1, -1, 1'b0);
    run_instr(mk_ir(5'd5), -1, -1, 1'b0);
    run_instr(mk_ir(5'd6), -1, 1, 1'b0);
    run_instr(mk_ir(5'd6), -1, 0, 1'b0);
    run_instr(mk_ir(5'd9), -1, -1, 1'b0);
    run_instr(mk_ir(5'd31), -1, -1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int unsigned sel;
      logic [4:0]  op;
      sel = $urandom_range(0, 7);
      op  = (sel == 7) ? 5'($urandom_range(8, 31)) : 5'(sel);
      run_instr(mk_ir(op), -1, -1, 1'b0);
    end

    run_instr(mk_ir(5'd2), -1, -1, 1'b1);
    run_instr(mk_ir(5'd0), -1, -1, 1'b0);

    run_instr(32'h3800_0000, -1, -1, 1'b0);
    repeat (20) cyc(1'b1, rbit(), rbit(), 32'h3800_0000, '0);
    cyc(1'b0, 1'b0, 1'b0, 32'h3800_0000, '0);
    cyc(1'b1, 1'b0, 1'b0, 32'h3800_0000, '0);
    run_instr(mk_ir(5'd3), -1, -1, 1'b0);

    @(negedge Clock);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL timeout sim_time=%0t limit=2000000", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
